d3s_phase_gen: RTL and testbench
================================

Name: d3s_phase_gen

Overview:
- Numerically-controlled phase generator for the D3S DAC path.
- Each clock it produces four consecutive 14-bit phase samples (lanes 0..3, one DAC word period apart) packed as 4x14 bits with a valid flag.
- Its outputs feed the sine-LUT stage's phase_divided_i / phase_valid_i inputs directly.
- Supports phase-continuous frequency (tuning word) updates and an absolute phase snap for resynchronisation.

Parameters:
- g_acc_bits, 32: phase accumulator width. Output is the top 14 bits; must be >= 16.

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  reset, asynchronous, active-low
- enable_i  in  1  level; 1 = generate, 0 = stop and flush
- ftw_i  in  g_acc_bits  frequency tuning word: per-lane phase increment
- ftw_load_i  in  1  strobe: capture ftw_i
- snap_i  in  1  strobe: load accumulator with snap_phase_i
- snap_phase_i  in  g_acc_bits  absolute lane-0 phase for snap
- phase_divided_o  out  4*14  {lane3, lane2, lane1, lane0}, lane k at bits [14k+:14]
- phase_valid_o  out  1  phase_divided_o holds a valid block
- running_o  out  1  FSM in RUN

Behaviour:
- Reset (async, active-low): acc=0, ftw_q=0, lane pipeline=0, state=IDLE. Outputs phase_divided_o=0, phase_valid_o=0, running_o=0.
- FSM states IDLE, PRIME, RUN; registered state S.
  - IDLE -> PRIME when enable_i=1.
  - PRIME: 2-cycle counter, then -> RUN.
  - Any state -> IDLE when enable_i=0, taking priority at the same edge.
- acc advances only when S is PRIME or RUN: acc <= acc + 4*ftw_q, modulo 2^g_acc_bits. In IDLE it holds.
- snap_i=1 at any state: acc <= snap_phase_i, overriding the increment on that edge.
- ftw_load_i=1: ftw_q <= ftw_i on that edge. The same edge's acc increment still uses the old ftw_q (phase-continuous).
- Stage 1 (registered): lane_k <= acc + k*ftw_q for k=0..3, modulo 2^g_acc_bits.
  - 2F = ftw_q<<1; 3F = ftw_q + (ftw_q<<1).
  - All four lanes of one block always use the same ftw_q.
- Stage 2 (registered): phase_divided_o lane k <= lane_k[g_acc_bits-1 -: 14]. Truncation, no rounding, no dithering.
- Valid pipe: v1 <= (S != IDLE); phase_valid_o <= v1.
  - Enable sampled at edge e0 -> phase_valid_o=1 after e2; the first block is for the acc value at e1.
  - running_o rises together with phase_valid_o.
- enable_i=0 sampled: S -> IDLE, v1 and phase_valid_o cleared at that same edge (in-flight blocks dropped). phase_divided_o holds its last value; acc holds.
- snap_i and ftw_load_i in the same cycle: both apply. The first block after the snap is lane_k = snap + k*F_new.
- Snap in RUN: phase_valid_o stays high; the phase jump appears 2 edges after the snap edge.
- Wrap-around: natural modulo arithmetic, no saturation, no flag.
- Throughput: one 4-lane block per clock, no backpressure.

Decomposition:
- Shared package d3s_pkg:
  - c_d3s_lanes = 4
  - c_d3s_phase_bits = 14
  - FSM state enum t_phase_gen_state
  - a helper that packs lanes into the 4*14 bus; the LUT stage uses the same packing
- One sub-module is natural: d3s_phase_lane_calc. It holds the registered stage-1 lane adders (acc, ftw in; 4 lanes out) and is reused by future interpolating variants.

Test Plan:
- Reset: assert rst_n_i mid-RUN -> all outputs 0 immediately, with no clock required.
- ftw=2^28, enable_i=1 at e0 -> valid after e2.
  - Blocks: {3072,2048,1024,0}, then {7168,6144,5120,4096}, then ..., then {15360,14336,13312,12288}.
  - 5th block wraps to {3072,2048,1024,0}.
- While running with ftw=2^28, load ftw=2^27 -> next block continues from 4096 at the new step. Example: {5632,5120,4608,4096}. No discontinuity at lane 0.
- snap_i with snap_phase_i=0x8000_0000 in RUN -> 2 edges later lane0=8192, with continuous valid. Snap+load ftw=0 in the same cycle -> all lanes 8192 steadily.
- Drop enable_i for 1 cycle -> phase_valid_o and running_o low for 3 cycles, then high again.
  - Resumes from the held acc (no reset to 0).
  - running_o and phase_valid_o rise together.
- Random ftw/snap/enable sequences against a reference model -> bit-exact lanes and valid on every cycle.

Source files
------------

// File: rtl/d3s_pkg.sv
// ---------------------------------------------------------------------------
// d3s_pkg
// Shared definitions for the D3S DAC phase path: lane geometry, the phase
// generator FSM state type and the lane packing helper used by both the
// phase generator and the downstream sine-LUT stage.
// ---------------------------------------------------------------------------
package d3s_pkg;

    localparam int c_d3s_lanes      = 4;
    localparam int c_d3s_phase_bits = 14;
    localparam int c_d3s_bus_bits   = c_d3s_lanes * c_d3s_phase_bits;

    // Number of cycles spent in PRIME before RUN; matches the two-stage
    // lane pipeline so running_o rises together with the first valid block.
    localparam int c_d3s_prime_cycles = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } t_phase_gen_state;

    typedef logic [c_d3s_lanes-1:0][c_d3s_phase_bits-1:0] t_lane_words;

    // Lane k lands at bits [14k +: 14]; the LUT stage unpacks the same way.
    function automatic logic [c_d3s_bus_bits-1:0] f_pack_lanes(input t_lane_words i_words);
        logic [c_d3s_bus_bits-1:0] v_bus;
        v_bus = '0;
        for (int k = 0; k < c_d3s_lanes; k++) begin
            v_bus[k*c_d3s_phase_bits +: c_d3s_phase_bits] = i_words[k];
        end
        return v_bus;
    endfunction

endpackage : d3s_pkg

// File: rtl/d3s_phase_lane_calc.sv
// ---------------------------------------------------------------------------
// d3s_phase_lane_calc
// Registered stage-1 lane adders: from the lane-0 accumulator value and the
// per-lane increment, produce the four full-width lane phases
// lane_k = acc + k*ftw (mod 2^g_acc_bits).
//
// Ports:
//   i_clk    system clock
//   i_rst_n  asynchronous active-low reset
//   i_acc    lane-0 accumulator value
//   i_ftw    per-lane phase increment
//   o_lanes  registered lane phases, o_lanes[k] = lane k
// ---------------------------------------------------------------------------
module d3s_phase_lane_calc
    import d3s_pkg::*;
#(
    parameter int g_acc_bits = 32
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic [g_acc_bits-1:0]                  i_acc,
    input  logic [g_acc_bits-1:0]                  i_ftw,
    output logic [c_d3s_lanes-1:0][g_acc_bits-1:0] o_lanes
);

    logic [g_acc_bits-1:0]                  w_ftw_x2;
    logic [g_acc_bits-1:0]                  w_ftw_x3;
    logic [c_d3s_lanes-1:0][g_acc_bits-1:0] r_lanes;

    // Multiples by shift/add only; no multiplier on the lane path.
    assign w_ftw_x2 = {i_ftw[g_acc_bits-2:0], 1'b0};
    assign w_ftw_x3 = i_ftw + w_ftw_x2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lanes <= '0;
        end else begin
            r_lanes[0] <= i_acc;
            r_lanes[1] <= i_acc + i_ftw;
            r_lanes[2] <= i_acc + w_ftw_x2;
            r_lanes[3] <= i_acc + w_ftw_x3;
        end
    end

    assign o_lanes = r_lanes;

endmodule : d3s_phase_lane_calc

// File: rtl/d3s_phase_gen.sv
// ---------------------------------------------------------------------------
// d3s_phase_gen
// Numerically-controlled phase generator for the D3S DAC path. Every clock
// it emits a block of four consecutive 14-bit phase samples (one DAC word
// apart) for the sine-LUT stage. Supports phase-continuous tuning word
// updates and an absolute phase snap.
//
// Ports:
//   clk_i            system clock
//   rst_n_i          asynchronous active-low reset
//   enable_i         1 = generate, 0 = stop and flush in-flight blocks
//   ftw_i            per-lane phase increment
//   ftw_load_i       strobe: capture ftw_i
//   snap_i           strobe: load accumulator with snap_phase_i
//   snap_phase_i     absolute lane-0 phase for snap
//   phase_divided_o  {lane3, lane2, lane1, lane0}, 14 bits each
//   phase_valid_o    phase_divided_o holds a valid block
//   running_o        FSM in RUN
//
// FSM states
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_IDLE  | stopped; accumulator holds, no blocks in flight
//   ST_PRIME | filling the two-stage lane pipeline (2 cycles)
//   ST_RUN   | one valid 4-lane block per clock
// ---------------------------------------------------------------------------
module d3s_phase_gen
    import d3s_pkg::*;
#(
    parameter int g_acc_bits = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_n_i,
    input  logic                      enable_i,
    input  logic [g_acc_bits-1:0]     ftw_i,
    input  logic                      ftw_load_i,
    input  logic                      snap_i,
    input  logic [g_acc_bits-1:0]     snap_phase_i,
    output logic [c_d3s_bus_bits-1:0] phase_divided_o,
    output logic                      phase_valid_o,
    output logic                      running_o
);

    if (g_acc_bits < 16) begin : g_bad_acc_bits
        $error("d3s_phase_gen: g_acc_bits must be >= 16");
    end

    localparam logic [0:0] c_prime_load = 1'(c_d3s_prime_cycles - 1);

    t_phase_gen_state                       r_state;
    logic [0:0]                             r_prime_cnt;
    logic                                   r_running;

    logic [g_acc_bits-1:0]                  r_acc;
    logic [g_acc_bits-1:0]                  r_ftw_q;
    logic                                   r_v1;
    logic                                   r_valid;
    logic [c_d3s_bus_bits-1:0]              r_phase;

    logic                                   w_active;
    logic                                   w_acc_adv;
    logic [g_acc_bits-1:0]                  w_acc_step;
    logic [c_d3s_lanes-1:0][g_acc_bits-1:0] w_lanes;
    t_lane_words                            w_lane_words;
    logic                                   w_out_load;

    // enable_i low overrides everything at the same edge.
    assign w_active   = (r_state != ST_IDLE) && enable_i;
    assign w_acc_adv  = w_active;
    assign w_acc_step = {r_ftw_q[g_acc_bits-3:0], 2'b00};
    assign w_out_load = r_v1 && enable_i;

    // -----------------------------------------------------------------------
    // Sequencing FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= ST_IDLE;
            r_prime_cnt <= '0;
            r_running   <= 1'b0;
        end else if (!enable_i) begin
            r_state     <= ST_IDLE;
            r_prime_cnt <= '0;
            r_running   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state     <= ST_PRIME;
                    r_prime_cnt <= c_prime_load;
                    r_running   <= 1'b0;
                end
                ST_PRIME: begin
                    if (r_prime_cnt == '0) begin
                        r_state   <= ST_RUN;
                        r_running <= 1'b1;
                    end else begin
                        r_prime_cnt <= r_prime_cnt - 1'b1;
                    end
                end
                ST_RUN: begin
                    r_running <= 1'b1;
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_prime_cnt <= '0;
                    r_running   <= 1'b0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Accumulator and tuning word. The increment on a load edge still uses
    // the old ftw_q, which keeps the phase continuous across the update.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_acc   <= '0;
            r_ftw_q <= '0;
        end else begin
            if (snap_i) begin
                r_acc <= snap_phase_i;
            end else if (w_acc_adv) begin
                r_acc <= r_acc + w_acc_step;
            end
            if (ftw_load_i) begin
                r_ftw_q <= ftw_i;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Stage 1: lane adders (acc and ftw_q sampled together so a block never
    // mixes tuning words).
    // -----------------------------------------------------------------------
    d3s_phase_lane_calc #(
        .g_acc_bits (g_acc_bits)
    ) u_lane_calc (
        .i_clk   (clk_i),
        .i_rst_n (rst_n_i),
        .i_acc   (r_acc),
        .i_ftw   (r_ftw_q),
        .o_lanes (w_lanes)
    );

    for (genvar k = 0; k < c_d3s_lanes; k++) begin : g_trunc
        assign w_lane_words[k] = w_lanes[k][g_acc_bits-1 -: c_d3s_phase_bits];
    end

    // -----------------------------------------------------------------------
    // Stage 2: truncated output block and valid pipe. A disable edge drops
    // any block in flight but leaves the last output word on the bus.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_v1    <= 1'b0;
            r_valid <= 1'b0;
            r_phase <= '0;
        end else begin
            r_v1    <= w_active;
            r_valid <= w_out_load;
            if (w_out_load) begin
                r_phase <= f_pack_lanes(w_lane_words);
            end
        end
    end

    assign phase_divided_o = r_phase;
    assign phase_valid_o   = r_valid;
    assign running_o       = r_running;

endmodule : d3s_phase_gen

// File: tb/tb_d3s_phase_gen.sv
module tb_d3s_phase_gen;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] ftw;
    logic        ftw_load;
    logic        snap;
    logic [31:0] snap_phase;
    logic [55:0] phase_divided;
    logic        phase_valid;
    logic        running;

    int checks   = 0;
    int failures = 0;

    d3s_phase_gen #(.g_acc_bits(32)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .enable_i        (enable),
        .ftw_i           (ftw),
        .ftw_load_i      (ftw_load),
        .snap_i          (snap),
        .snap_phase_i    (snap_phase),
        .phase_divided_o (phase_divided),
        .phase_valid_o   (phase_valid),
        .running_o       (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        ld;
        logic [31:0] ftw;
        logic        snap;
        logic [31:0] sph;
        logic        ev;
        logic        er;
        logic [55:0] ed;
    } t_vec;

    typedef struct {
        logic        v;
        logic        r;
        logic [55:0] d;
    } t_exp;

    t_vec vecs[$];
    t_exp sb[$];

    // Reference model state: 0 idle, 1/2 priming, 3 run.
    int          m_st;
    logic [31:0] m_acc;
    logic [31:0] m_ftw;
    logic [31:0] m_lane [4];
    logic        m_v1;
    logic        m_valid;
    logic        m_run;
    logic [55:0] m_out;

    function automatic logic [55:0] p4(input int a3, input int a2, input int a1, input int a0);
        return {14'(a3), 14'(a2), 14'(a1), 14'(a0)};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic addv(input logic en, input logic ld, input logic [31:0] f,
                        input logic sn, input logic [31:0] sp,
                        input logic ev, input logic er, input logic [55:0] ed);
        t_vec v;
        v.en = en; v.ld = ld; v.ftw = f; v.snap = sn; v.sph = sp;
        v.ev = ev; v.er = er; v.ed = ed;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic en, input logic ld, input logic [31:0] f,
                         input logic sn, input logic [31:0] sp);
        enable     = en;
        ftw_load   = ld;
        ftw        = f;
        snap       = sn;
        snap_phase = sp;
    endtask

    // Advance one clock and compare the DUT against the oldest expectation.
    task automatic cycle_and_check(input string tag);
        t_exp e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"},   64'(phase_valid),   64'(e.v));
            chk({tag, "_running"}, 64'(running),       64'(e.r));
            chk({tag, "_phase"},   64'(phase_divided), 64'(e.d));
        end
    endtask

    task automatic mdl_reset();
        m_st = 0; m_acc = '0; m_ftw = '0;
        for (int k = 0; k < 4; k++) m_lane[k] = '0;
        m_v1 = 0; m_valid = 0; m_run = 0; m_out = '0;
    endtask

    task automatic mdl_edge(input logic en, input logic ld, input logic [31:0] f,
                            input logic sn, input logic [31:0] sp);
        logic [31:0] n_lane [4];
        logic        adv;
        int          n_st;
        t_exp        e;
        adv = (m_st != 0) && en;
        for (int k = 0; k < 4; k++) n_lane[k] = m_acc + m_ftw * 32'(k);
        if (m_v1 && en)
            m_out = {m_lane[3][31:18], m_lane[2][31:18], m_lane[1][31:18], m_lane[0][31:18]};
        m_valid = m_v1 && en;
        m_v1    = adv;
        if (sn)       m_acc = sp;
        else if (adv) m_acc = m_acc + m_ftw * 32'd4;
        if (ld) m_ftw = f;
        for (int k = 0; k < 4; k++) m_lane[k] = n_lane[k];
        n_st  = !en ? 0 : ((m_st == 3) ? 3 : m_st + 1);
        m_st  = n_st;
        m_run = (m_st == 3);
        e.v = m_valid; e.r = m_run; e.d = m_out;
        sb.push_back(e);
    endtask

    localparam logic [31:0] F = 32'h1000_0000;
    localparam logic [31:0] H = 32'h0800_0000;
    localparam logic [31:0] S = 32'h8000_0000;

    initial begin
        t_exp e;
        rst_n = 1'b0;
        drive(0, 0, '0, 0, '0);

        // Directed sequence: start-up, wrap, ftw change, snaps, enable drop.
        addv(0,1,F,0,0, 0,0, '0);
        addv(1,0,0,0,0, 0,0, '0);
        addv(1,0,0,0,0, 0,0, '0);
        addv(1,0,0,0,0, 1,1, p4(3072,2048,1024,0));
        addv(1,0,0,0,0, 1,1, p4(7168,6144,5120,4096));
        addv(1,0,0,0,0, 1,1, p4(11264,10240,9216,8192));
        addv(1,0,0,0,0, 1,1, p4(15360,14336,13312,12288));
        addv(1,0,0,0,0, 1,1, p4(3072,2048,1024,0));
        addv(1,1,H,0,0, 1,1, p4(7168,6144,5120,4096));
        addv(1,0,0,0,0, 1,1, p4(11264,10240,9216,8192));
        addv(1,0,0,0,0, 1,1, p4(13824,13312,12800,12288));
        addv(1,0,0,0,0, 1,1, p4(15872,15360,14848,14336));
        addv(1,0,0,1,S, 1,1, p4(1536,1024,512,0));
        addv(1,0,0,0,0, 1,1, p4(3584,3072,2560,2048));
        addv(1,0,0,0,0, 1,1, p4(9728,9216,8704,8192));
        addv(1,1,0,1,S, 1,1, p4(11776,11264,10752,10240));
        addv(1,0,0,0,0, 1,1, p4(13824,13312,12800,12288));
        addv(1,0,0,0,0, 1,1, p4(8192,8192,8192,8192));
        addv(1,0,0,0,0, 1,1, p4(8192,8192,8192,8192));
        addv(1,1,F,0,0, 1,1, p4(8192,8192,8192,8192));
        addv(1,0,0,0,0, 1,1, p4(8192,8192,8192,8192));
        addv(0,0,0,0,0, 0,0, p4(8192,8192,8192,8192));
        addv(1,0,0,0,0, 0,0, p4(8192,8192,8192,8192));
        addv(1,0,0,0,0, 0,0, p4(8192,8192,8192,8192));
        addv(1,0,0,0,0, 1,1, p4(15360,14336,13312,12288));
        addv(1,0,0,0,0, 1,1, p4(3072,2048,1024,0));

        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid",   64'(phase_valid),   64'd0);
        chk("reset_running", 64'(running),       64'd0);
        chk("reset_phase",   64'(phase_divided), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].en, vecs[i].ld, vecs[i].ftw, vecs[i].snap, vecs[i].sph);
            e.v = vecs[i].ev; e.r = vecs[i].er; e.d = vecs[i].ed;
            sb.push_back(e);
            cycle_and_check($sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-RUN: outputs must clear without a clock edge.
        chk("pre_reset_valid", 64'(phase_valid), 64'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid",   64'(phase_valid),   64'd0);
        chk("async_reset_running", 64'(running),       64'd0);
        chk("async_reset_phase",   64'(phase_divided), 64'd0);
        drive(0, 0, '0, 0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mdl_reset();
        sb.delete();

        // Random enable/ftw/snap traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic        en, ld, sn;
            logic [31:0] f, sp;
            en = ($urandom_range(0, 9) != 0);
            ld = ($urandom_range(0, 7) == 0);
            sn = ($urandom_range(0, 15) == 0);
            f  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 1 << 20)) : $urandom;
            sp = $urandom;
            drive(en, ld, f, sn, sp);
            mdl_edge(en, ld, f, sn, sp);
            cycle_and_check($sformatf("rand%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_d3s_phase_gen
